soc_system_led_sequencer: RTL and testbench

Autonomous pattern sequencer and write arbiter for the 10-bit LED PIO slave.
- Generates timed LED patterns (rotate, bounce, binary count, hold) and writes each new pattern to the PIO data register over its Avalon-MM slave port.
- Shares that slave port with a host override path; the host always wins.
- Sits between the HPS-side control logic and the LED PIO, in the same clock domain.

---
 rtl/soc_system_led_pkg.sv | 31 +++
 rtl/soc_system_led_prescaler.sv | 45 ++++
 rtl/soc_system_led_sequencer.sv | 167 ++++++++++++++++
 tb/tb_soc_system_led_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_led_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_led_pkg
// Shared types and constants for the LED pattern sequencer:
//   mode_e  - pattern generator mode (rotate, bounce, binary count, hold)
//   state_e - PIO write FSM state (IDLE, WRITE)
//   dir_e   - bounce direction (LEFT, RIGHT)
//   PIO_DATA_ADDR - word address of the PIO data register
// -----------------------------------------------------------------------------
package soc_system_led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_DATA_W    = 32;

endpackage

// File: rtl/soc_system_led_prescaler.sv
// -----------------------------------------------------------------------------
// soc_system_led_prescaler
// Step-rate prescaler. Counts clocks while enabled and fires a one-cycle tick
// every max(period,1) clocks.
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   enable  - 1 = count; 0 = count held at zero, no tick
//   period  - clocks per tick; 0 behaves as 1
//   tick    - step request, valid in the cycle the count reaches its limit
// -----------------------------------------------------------------------------
module soc_system_led_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  // NOTE: every variable assigned in always_comb gets a value on all paths
  // (here by construction of the ternary) so no latch is inferred.
  always_comb begin
    limit = (period == '0) ? '0 : period - CNT_W'(1);
    // >= rather than == so that shrinking the period below the running count
    // produces a tick immediately instead of waiting for a 2^CNT_W wrap.
    tick  = enable && (count >= limit);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/soc_system_led_sequencer.sv
// -----------------------------------------------------------------------------
// soc_system_led_sequencer
// Autonomous LED pattern sequencer and write arbiter for the LED PIO slave.
// Each served prescaler tick advances the pattern and issues one zero-wait
// Avalon-MM write; a host request forces a pattern and always wins over a tick.
//   clk, reset_n           - clock, asynchronous active-low reset
//   enable                 - run the prescaler (host path works regardless)
//   mode                   - 0 rotate-left, 1 bounce, 2 increment, 3 hold
//   period                 - clocks per step (0 treated as 1)
//   host_write/_writedata  - single-cycle forced-pattern request
//   host_ack               - pulses in the WRITE cycle carrying a host pattern
//   pio_address/chipselect/write_n/writedata - Avalon-MM master to PIO slave
//   pattern                - current pattern register
//   busy                   - high while the FSM is in WRITE
// -----------------------------------------------------------------------------
module soc_system_led_sequencer
  import soc_system_led_pkg::*;
#(
  parameter int               WIDTH         = 10,
  parameter int               CNT_W         = 32,
  parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(10'h33F)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      period,
  input  logic                  host_write,
  input  logic [WIDTH-1:0]      host_writedata,
  output logic                  host_ack,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [PIO_DATA_W-1:0] pio_writedata,
  output logic [WIDTH-1:0]      pattern,
  output logic                  busy
);

  typedef struct packed {
    logic [WIDTH-1:0] pattern;
    dir_e             dir;
  } step_t;

  // Next pattern and bounce direction for one served tick.
  function automatic step_t next_step(input logic [WIDTH-1:0] cur,
                                      input dir_e d, input mode_e m);
    step_t s;
    s.pattern = cur;
    s.dir     = d;
    case (m)
      MODE_ROTATE: begin
        s.pattern = (cur == '0) ? WIDTH'(1) : {cur[WIDTH-2:0], cur[WIDTH-1]};
      end
      MODE_BOUNCE: begin
        if (cur == '0) begin
          s.pattern = WIDTH'(1);
        end else if (d == LEFT) begin
          if (cur[WIDTH-1]) begin
            s.dir     = RIGHT;
            s.pattern = cur >> 1;
          end else begin
            s.pattern = cur << 1;
          end
        end else begin
          if (cur[0]) begin
            s.dir     = LEFT;
            s.pattern = cur << 1;
          end else begin
            s.pattern = cur >> 1;
          end
        end
      end
      MODE_COUNT: s.pattern = cur + WIDTH'(1);
      default:    s.pattern = cur;
    endcase
    return s;
  endfunction

  state_e           state;
  dir_e             dir;
  logic             tick;
  logic             tick_pending;
  logic             host_pending;
  logic [WIDTH-1:0] host_data;

  step_t            step;
  logic             host_req;
  logic [WIDTH-1:0] host_sel;
  logic             issue;
  logic [WIDTH-1:0] pattern_nxt;

  soc_system_led_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .period  (period),
    .tick    (tick)
  );

  always_comb begin
    step        = next_step(pattern, dir, mode_e'(mode));
    host_req    = host_write || host_pending;
    // A fresh host request in IDLE supersedes an older pending one.
    host_sel    = host_write ? host_writedata : host_data;
    issue       = (state == IDLE) && (host_req || tick || tick_pending);
    pattern_nxt = host_req ? host_sel : step.pattern;
  end

  // The PIO is always addressed at its data register.
  assign pio_address = PIO_DATA_ADDR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pattern        <= RESET_PATTERN;
      dir            <= LEFT;
      tick_pending   <= 1'b0;
      host_pending   <= 1'b0;
      host_data      <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      host_ack       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            // Outputs are loaded on entry so they are valid for exactly the
            // single WRITE cycle.
            state          <= WRITE;
            pattern        <= pattern_nxt;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{(PIO_DATA_W-WIDTH){1'b0}}, pattern_nxt};
            busy           <= 1'b1;
            host_ack       <= host_req;
            if (host_req) begin
              host_pending <= 1'b0;
              // A tick losing arbitration to the host is deferred, not lost.
              if (tick) tick_pending <= 1'b1;
            end else begin
              dir          <= step.dir;
              tick_pending <= 1'b0;
            end
          end
        end
        WRITE: begin
          state          <= IDLE;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          busy           <= 1'b0;
          host_ack       <= 1'b0;
          if (tick) tick_pending <= 1'b1;
          if (host_write) begin
            host_pending <= 1'b1;
            host_data    <= host_writedata;
          end
        end
        default: state <= IDLE;
      endcase
      // Disabling the sequencer discards any step that has not been served.
      if (!enable) tick_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_soc_system_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_soc_system_led_sequencer
// Scoreboard bench: each expected PIO write (data, host_ack, clock gap since
// the previous write) is queued as stimulus is driven and compared when the
// DUT strobes pio_write_n.
// -----------------------------------------------------------------------------
module tb_soc_system_led_sequencer;

  localparam int WIDTH = 10;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [CNT_W-1:0]  period = 32'd1;
  logic              host_write = 1'b0;
  logic [WIDTH-1:0]  host_writedata = '0;
  logic              host_ack;
  logic [1:0]        pio_address;
  logic              pio_chipselect;
  logic              pio_write_n;
  logic [31:0]       pio_writedata;
  logic [WIDTH-1:0]  pattern;
  logic              busy;

  soc_system_led_sequencer #(
    .WIDTH         (WIDTH),
    .CNT_W         (CNT_W),
    .RESET_PATTERN (10'h33F)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .mode           (mode),
    .period         (period),
    .host_write     (host_write),
    .host_writedata (host_writedata),
    .host_ack       (host_ack),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pattern        (pattern),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ack;
    int               gap;   // clocks since previous write; 0 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [WIDTH-1:0] d, input logic a, input int g);
    exp_t e;
    e.data = d;
    e.ack  = a;
    e.gap  = g;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic host_poke(input logic [WIDTH-1:0] d);
    @(negedge clk);
    host_write     = 1'b1;
    host_writedata = d;
    @(negedge clk);
    host_write     = 1'b0;
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && pio_chipselect && !pio_write_n) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", pio_writedata, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_data", pio_writedata, {22'b0, mon_e.data});
        check("wr_ack", 32'(host_ack), 32'(mon_e.ack));
        check("wr_addr", 32'(pio_address), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        if (mon_e.gap != 0) check("wr_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
      end
      last_cyc = cyc;
    end else if (reset_n && host_ack) begin
      check("stray_ack", 32'(host_ack), 32'd0);
    end
  end

  logic [WIDTH-1:0] bounce_tbl [12] = '{10'h200, 10'h100, 10'h080, 10'h040,
                                         10'h020, 10'h010, 10'h008, 10'h004,
                                         10'h002, 10'h001, 10'h002, 10'h004};

  initial begin
    int  rel;
    bit  seen;

    // Reset values while reset is held
    #3 reset_n = 1'b0;
    #1;
    check("rst_cs", 32'(pio_chipselect), 32'd0);
    check("rst_wr_n", 32'(pio_write_n), 32'd1);
    check("rst_addr", 32'(pio_address), 32'd0);
    check("rst_wdata", pio_writedata, 32'd0);
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pattern", 32'(pattern), 32'h33F);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Disabled: no writes for 100 cycles (monitor flags any strobe)
    repeat (100) @(negedge clk);
    #1;
    check("idle_pattern", 32'(pattern), 32'h33F);
    check("idle_cs", 32'(pio_chipselect), 32'd0);
    check("idle_wr_n", 32'(pio_write_n), 32'd1);

    // Rotate-left, period 4, from 0x001 through the wrap
    expect_write(10'h001, 1'b1, 0);
    host_poke(10'h001);
    drain(20);
    mode = 2'd0; period = 32'd4; enable = 1'b1;
    for (int k = 1; k < 10; k++) expect_write(WIDTH'(1) << k, 1'b0, (k == 1) ? 0 : 4);
    expect_write(10'h001, 1'b0, 4);
    drain(100);
    enable = 1'b0;

    // Bounce, period 1, from 0x100: flips at bit 9 and at bit 0
    expect_write(10'h100, 1'b1, 0);
    host_poke(10'h100);
    drain(20);
    mode = 2'd1; period = 32'd1; enable = 1'b1;
    for (int i = 0; i < 12; i++) expect_write(bounce_tbl[i], 1'b0, (i == 0) ? 0 : 2);
    drain(100);
    enable = 1'b0;
    check("bounce_end_pattern", 32'(pattern), 32'h004);

    // Binary count, period 2, from 0x3FE through the wrap
    expect_write(10'h3FE, 1'b1, 0);
    host_poke(10'h3FE);
    drain(20);
    mode = 2'd2; period = 32'd2; enable = 1'b1;
    expect_write(10'h3FF, 1'b0, 0);
    expect_write(10'h000, 1'b0, 2);
    expect_write(10'h001, 1'b0, 2);
    drain(50);
    enable = 1'b0;

    // Hold, period 3: same data, still written every step
    mode = 2'd3; period = 32'd3;
    @(negedge clk);
    enable = 1'b1;
    expect_write(10'h001, 1'b0, 0);
    expect_write(10'h001, 1'b0, 3);
    drain(50);
    enable = 1'b0;

    // Host request during WRITE is held and served next
    expect_write(10'h0F0, 1'b1, 0);
    expect_write(10'h00F, 1'b1, 2);
    @(negedge clk);
    host_write = 1'b1; host_writedata = 10'h0F0;
    @(negedge clk);
    host_writedata = 10'h00F;
    @(negedge clk);
    host_write = 1'b0;
    drain(20);

    // Host and tick in the same cycle: host first, then the deferred tick
    mode = 2'd0; period = 32'd1;
    expect_write(10'h155, 1'b1, 0);
    expect_write(10'h2AA, 1'b0, 2);
    @(negedge clk);
    enable = 1'b1; host_write = 1'b1; host_writedata = 10'h155;
    @(negedge clk);
    host_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("collision_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    // Reset in the middle of a WRITE
    mode = 2'd2; period = 32'd5; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (pio_chipselect) seen = 1'b1;
    end
    check("mid_write_seen", 32'(seen), 32'd1);
    check("mid_write_data", pio_writedata, 32'h2AB);
    reset_n = 1'b0;
    #1;
    check("abort_cs", 32'(pio_chipselect), 32'd0);
    check("abort_wr_n", 32'(pio_write_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wdata", pio_writedata, 32'd0);
    check("abort_pattern", 32'(pattern), 32'h33F);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    expect_write(10'h340, 1'b0, 0);
    drain(40);
    check("rst_release_latency", 32'(last_cyc - rel), 32'd5);
    enable = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    check("queue_empty_end", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
